// File: rtl/dds_cfg_arb.sv
// Two-requester arbiter/sequencer for the dds_chirp config port: latches the granted
// parameter set and runs the 4-phase REQ/ACK crossing. Optional handshake timeout: DDS_ARB_TIMEOUT_EN.
module dds_cfg_arb #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        REQ0,
    input  logic [47:0] FREQ0,
    input  logic [47:0] STEP0,
    input  logic [31:0] RATE0,
    input  logic        START0,
    output logic        DONE0,
    input  logic        REQ1,
    input  logic [47:0] FREQ1,
    input  logic [47:0] STEP1,
    input  logic [31:0] RATE1,
    input  logic        START1,
    output logic        DONE1,
    input  logic        LOCK1,
    output logic [47:0] DDS_freq,
    output logic [47:0] DDS_delta_freq,
    output logic [31:0] DDS_delta_rate,
    output logic        DDS_REQ,
    input  logic        DDS_ACK,
    output logic        DDS_start,
    output logic [1:0]  GNT,
    output logic        BUSY,
    output logic        ERR,
    input  logic        ERR_CLR
);

    typedef enum logic [1:0] {S_IDLE, S_REQ_HI, S_REQ_LO, S_DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   start_l;
    logic                   grant0;
    logic                   grant1;
    logic                   tmo_fire;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], DDS_ACK};
        end
    end

    assign ack_s  = ack_sync[SYNC_STAGES-1];
    assign grant0 = REQ0;
    assign grant1 = !REQ0 && REQ1 && !LOCK1;

`ifdef DDS_ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] phase_cnt;
    logic        err_q;

    assign tmo_fire = ((state == S_REQ_HI) || (state == S_REQ_LO)) && (phase_cnt == CNT_LAST);
    assign ERR      = err_q;

    // Counter restarts on entry to each handshake phase.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if ((state == S_IDLE && (grant0 || grant1)) ||
                     (state == S_REQ_HI && ack_s && !tmo_fire)) begin
            phase_cnt <= '0;
        end else if (state == S_REQ_HI || state == S_REQ_LO) begin
            phase_cnt <= phase_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (tmo_fire) begin
            err_q <= 1'b1;
        end else if (ERR_CLR) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign tmo_fire   = 1'b0;
    assign ERR        = 1'b0;
    assign unused_cfg = ERR_CLR | (TIMEOUT < 1);
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            DONE0          <= 1'b0;
            DONE1          <= 1'b0;
            DDS_freq       <= '0;
            DDS_delta_freq <= '0;
            DDS_delta_rate <= '0;
            DDS_REQ        <= 1'b0;
            DDS_start      <= 1'b0;
            GNT            <= '0;
            BUSY           <= 1'b0;
            start_l        <= 1'b0;
        end else begin
            DONE0     <= 1'b0;
            DONE1     <= 1'b0;
            DDS_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant0) begin
                        GNT            <= 2'b01;
                        DDS_freq       <= FREQ0;
                        DDS_delta_freq <= STEP0;
                        DDS_delta_rate <= RATE0;
                        start_l        <= START0;
                        DDS_REQ        <= 1'b1;
                        BUSY           <= 1'b1;
                        state          <= S_REQ_HI;
                    end else if (grant1) begin
                        GNT            <= 2'b10;
                        DDS_freq       <= FREQ1;
                        DDS_delta_freq <= STEP1;
                        DDS_delta_rate <= RATE1;
                        start_l        <= START1;
                        DDS_REQ        <= 1'b1;
                        BUSY           <= 1'b1;
                        state          <= S_REQ_HI;
                    end
                end
                S_REQ_HI: begin
                    if (tmo_fire) begin
                        DDS_REQ <= 1'b0;
                        DONE0   <= GNT[0];
                        DONE1   <= GNT[1];
                        state   <= S_DONE;
                    end else if (ack_s) begin
                        DDS_REQ <= 1'b0;
                        state   <= S_REQ_LO;
                    end
                end
                S_REQ_LO: begin
                    if (tmo_fire) begin
                        DDS_REQ <= 1'b0;
                        DONE0   <= GNT[0];
                        DONE1   <= GNT[1];
                        state   <= S_DONE;
                    end else if (!ack_s) begin
                        DONE0     <= GNT[0];
                        DONE1     <= GNT[1];
                        DDS_start <= start_l;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dds_cfg_arb.md
Name: dds_cfg_arb

Overview:
- Arbiter and sequencer for the single dds_chirp configuration port (48 MHz side). Two requesters share it: ch0 is the synchroniser (MASTER_START DDS path) and ch1 is the MCU/maintenance path.
- It latches the granted parameter set and runs the 4-phase REQ/ACK crossing toward the 96 MHz DDS. After the ACK falls it optionally fires DDS_start and returns DONE to the winner.

Parameters:
- SYNC_STAGES, 2: flops in the DDS_ACK synchroniser (min 2).
- TIMEOUT, 1024: max CLK cycles per handshake phase (used only with the optional feature).

Ports:
- CLK  in  1  48 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- REQ0  in  1  ch0 request, level, held until DONE0
- FREQ0  in  48  ch0 DDS frequency word
- STEP0  in  48  ch0 frequency step
- RATE0  in  32  ch0 step rate
- START0  in  1  ch0: pulse DDS_start after load
- DONE0  out  1  ch0 completion, 1-cycle pulse
- REQ1/FREQ1/STEP1/RATE1/START1/DONE1: same as ch0, for ch1
- LOCK1  in  1  inhibits new ch1 grants (tie to En_Iz|En_Pr)
- DDS_freq  out  48  latched frequency to DDS
- DDS_delta_freq  out  48  latched step
- DDS_delta_rate  out  32  latched rate
- DDS_REQ  out  1  handshake request to DDS
- DDS_ACK  in  1  handshake acknowledge from DDS (96 MHz domain, asynchronous)
- DDS_start  out  1  1-cycle start pulse
- GNT  out  2  one-hot current owner, 00 = idle
- BUSY  out  1  high whenever state != IDLE
- ERR  out  1  sticky handshake timeout flag
- ERR_CLR  in  1  clears ERR

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including DDS_* parameters, DDS_REQ, GNT and ERR. The synchroniser flops clear to 0.
- ack_s is DDS_ACK after SYNC_STAGES flops. All handshake decisions use ack_s only.
- IDLE:
  - If REQ0=1: grant ch0, latch FREQ0/STEP0/RATE0/START0.
  - Else if REQ1=1 and LOCK1=0: grant ch1 and latch its set.
  - On grant at edge k: GNT, DDS_* and DDS_REQ=1 are registered at edge k. State becomes REQ_HI.
  - Simultaneous REQ0 and REQ1: ch0 wins (fixed priority). Starving ch1 is acceptable.
  - With LOCK1=1, REQ1 alone stays IDLE.
- REQ_HI: wait for ack_s=1, then DDS_REQ<=0 and go to REQ_LO.
- REQ_LO: wait for ack_s=0, then go to DONE.
- DONE (exactly 1 cycle):
  - DONEx=1 for the granted channel.
  - DDS_start=1 in the same cycle if the latched START=1.
  - Next state IDLE, GNT<=00.
- DDS_* hold their last loaded values after DONE and until the next grant.
- Requester contract: drop REQx at the edge that samples DONEx. The IDLE state after DONE must not re-grant a stale request.
- Mid-transfer changes:
  - Input parameter changes after the grant are ignored, because values are latched.
  - LOCK1 rising during a ch1 transfer does not abort it.
  - REQx falling mid-transfer does not abort it; DONEx is still pulsed.
- Latency with ack_s delay D: grant, then DDS_REQ high at edge k. DONE comes 1 cycle after ack_s falls.
- ERR_CLR=1 clears ERR. Timeout has priority over ERR_CLR in the same cycle.

Optional Feature:
- Macro DDS_ARB_TIMEOUT_EN, when defined:
  - A 16-bit phase counter clears on entering REQ_HI and REQ_LO and increments every cycle in those states.
  - At count == TIMEOUT-1: DDS_REQ<=0, ERR<=1 (sticky), state becomes DONE.
  - DONEx pulses, but DDS_start is suppressed.
- Undefined: no counter, ERR is tied to 0, ERR_CLR is ignored, and the handshake waits indefinitely.

Test Plan:
1. Reset, then REQ0=1 with FREQ0=48'h1000000000, STEP0=48'h100000, RATE0=32'h100, START0=1. Bench DDS ACKs 3 cycles after DDS_REQ and drops ACK 3 cycles after DDS_REQ falls -> DDS_freq=48'h1000000000, GNT=01, a single DONE0 pulse and one DDS_start pulse in the same cycle, BUSY low the next cycle.
2. REQ0 and REQ1 raised on the same edge -> ch0 is served first (GNT=01). ch1 is granted in the IDLE cycle after DONE0 (GNT=10). DONE1 comes with no DDS_start when START1=0.
3. LOCK1=1 with REQ1=1 for 100 cycles -> GNT stays 00 and DDS_REQ stays 0. LOCK1 falls -> ch1 is granted on the next edge. Then, with LOCK1 raised mid-transfer, the transfer still completes.
4. FREQ0 changed to 48'h2000000000 one cycle after the grant -> DDS_freq stays 48'h1000000000 until the next grant.
5. Assert rst_n=0 while in REQ_HI -> DDS_REQ, GNT and BUSY are 0 immediately (asynchronously). After release a fresh REQ0 is served normally.
6. DDS_ARB_TIMEOUT_EN defined, TIMEOUT=16, DDS never ACKs -> DDS_REQ falls 16 cycles after it rose, ERR=1, DONE0 pulses, no DDS_start. ERR_CLR -> ERR=0. Macro undefined: ERR stays 0 and BUSY stays 1.
